// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op codes, state encoding and op decode helpers for mul_div_unit
package md_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } md_state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/md_step.sv
// rtl/md_step.sv - one combinational shift-add (multiply) or restoring-subtract (divide) step
module md_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] opnd,
    input  logic [XLEN:0]   hi,
    input  logic [XLEN-1:0] lo,
    output logic [XLEN:0]   hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Multiply: {hi,lo} is the running product with the multiplier draining out of lo.
    // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
    always_comb begin
        sum     = hi + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi[XLEN-1:0], lo[XLEN-1]};
        diff    = shifted - {1'b0, opnd};
        if (is_div) begin
            hi_next = diff[XLEN] ? shifted : diff;
            lo_next = {lo[XLEN-2:0], ~diff[XLEN]};
        end else begin
            hi_next = {1'b0, sum[XLEN:1]};
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit with valid/ready handshake and flush
module mul_div_unit
    import md_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t       state;
    logic [2:0]      op_q;
    logic            sign_a;
    logic            sign_b;
    logic [CW-1:0]   count;
    logic [XLEN:0]   hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;

    logic [XLEN:0]   hi_c [UNROLL+1];
    logic [XLEN-1:0] lo_c [UNROLL+1];

    assign hi_c[0] = hi;
    assign lo_c[0] = lo;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        md_step #(.XLEN(XLEN)) u_step (
            .is_div  (is_div(op_q)),
            .opnd    (opnd),
            .hi      (hi_c[i]),
            .lo      (lo_c[i]),
            .hi_next (hi_c[i+1]),
            .lo_next (lo_c[i+1])
        );
    end

    logic            in_sa;
    logic            in_sb;
    logic            in_div;
    logic            by_zero;
    logic            overflow;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    always_comb begin
        in_sa    = is_signed_a(op) & a[XLEN-1];
        in_sb    = is_signed_b(op) & b[XLEN-1];
        mag_a    = in_sa ? -a : a;
        mag_b    = in_sb ? -b : b;
        in_div   = is_div(op);
        by_zero  = in_div && (b == '0);
        overflow = in_div && is_signed_b(op) && (a == MIN_VAL) && (b == '1);
    end

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod     = {hi[XLEN-1:0], lo};
        prod_fix = (sign_a ^ sign_b) ? -prod : prod;
        quo_fix  = (sign_a ^ sign_b) ? -lo : lo;
        rem_fix  = sign_a ? -hi[XLEN-1:0] : hi[XLEN-1:0];
        case (op_q)
            MD_MUL:                       fix_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_res = quo_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            op_q      <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            count     <= '0;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        op_q     <= op;
                        sign_a   <= in_sa;
                        sign_b   <= in_sb;
                        count    <= CW'(STEPS);
                        hi       <= '0;
                        lo       <= in_div ? mag_a : mag_b;
                        opnd     <= in_div ? mag_b : mag_a;
                        // Divide-by-zero and signed overflow bypass the iteration entirely
                        if (by_zero) begin
                            result    <= op[1] ? a : '1;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else if (overflow) begin
                            result    <= op[1] ? '0 : MIN_VAL;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    hi    <= hi_c[UNROLL];
                    lo    <= lo_c[UNROLL];
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    result    <= fix_res;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed and random scoreboard bench for mul_div_unit
module tb_mul_div_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN_VAL = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mul_div_unit #(.XLEN(XLEN), .UNROLL(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx, sy, zx, zy, p;
        logic [31:0] r;
        logic        ovf;
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        zx  = {32'd0, x};
        zy  = {32'd0, y};
        ovf = (x == MIN_VAL) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd2:    p = sx * zy;
            3'd3:    p = zx * zy;
            default: p = sx * sy;
        endcase
        case (o)
            3'd0:    r = p[31:0];
            3'd1, 3'd2, 3'd3: r = p[63:32];
            3'd4:    r = (y == 0) ? 32'hFFFF_FFFF : ovf ? MIN_VAL : 32'($signed(x) / $signed(y));
            3'd5:    r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6:    r = (y == 0) ? x : ovf ? 32'd0 : 32'($signed(x) % $signed(y));
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && (y == 0 || (!o[0] && x == MIN_VAL && y == 32'hFFFF_FFFF)))
            return 1;
        return 34;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int hold);
        int n;
        logic [31:0] held;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        exp_q.push_back(ref_md(o, x, y));
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                in_valid = 1'b0;
                op = 3'($urandom);
                a = $urandom;
                b = $urandom;
            end
        end while (!out_valid && n < 100);
        check("latency", 64'(n), 64'(exp_lat(o, x, y)));
        check("out_valid_rise", 64'(out_valid), 64'd1);
        held = result;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", 64'(result), 64'(held));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("result", 64'(result), 64'(exp_q.pop_front()));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_drop", 64'(out_valid), 64'd0);
        check("ready_back", 64'(in_ready), 64'd1);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN_VAL;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic seen;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'h0000_1234, 32'd0, 0);
        run_op(3'd7, 32'h0000_1234, 32'd0, 0);
        run_op(3'd4, MIN_VAL, 32'hFFFF_FFFF, 0);
        run_op(3'd6, MIN_VAL, 32'hFFFF_FFFF, 0);
        run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5);

        // Flush mid-CALC: the op must vanish without a result
        op = 3'd4;
        a = 32'hFFFF_FC18;
        b = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_result", 64'(seen), 64'd0);

        // Flush alongside a request in IDLE blocks the accept
        op = 3'd0;
        a = 32'd3;
        b = 32'd5;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_idle_not_accepted", 64'(in_ready), 64'd1);
        run_op(3'd5, 32'd100, 32'd7, 0);

        // Asynchronous reset in the middle of CALC
        op = 3'd1;
        a = 32'h1234_5678;
        b = 32'h9ABC_DEF0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 150; i++) begin
            run_op(3'($urandom), pick_val(), pick_val(), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
